// File: rtl/mux4_serializer_pkg.sv
// Shared constants for the 4:1 mux serializer: state encodings and select-index helpers.
package mux4_serializer_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    localparam logic [1:0] IDX_FIRST_LSB = 2'd0;
    localparam logic [1:0] IDX_FIRST_MSB = 2'd3;

    function automatic logic [1:0] first_idx(input bit msb_first);
        return msb_first ? IDX_FIRST_MSB : IDX_FIRST_LSB;
    endfunction

    // The final index of a word is the first index of the opposite order.
    function automatic logic [1:0] last_idx(input bit msb_first);
        return msb_first ? IDX_FIRST_LSB : IDX_FIRST_MSB;
    endfunction

endpackage

// File: rtl/mux4_serializer_mux.sv
// 4:1 case-based mux, identical to the one in the downstream mux stage.
module mux4to1_case (
    input  logic [3:0] d,
    input  logic [1:0] s,
    output logic       y
);

    always_comb begin
        y = 1'b0;
        case (s)
            2'd0: y = d[0];
            2'd1: y = d[1];
            2'd2: y = d[2];
            2'd3: y = d[3];
            default: y = 1'b0;
        endcase
    end

endmodule

// File: rtl/mux4_serializer.sv
// Latches a 4-bit word and walks the 4:1 mux select across it, one bit per output beat.
module mux4_serializer
    import mux4_serializer_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_bit,
    output logic       out_last,
    output logic [1:0] sel,
    output logic       busy
);

    localparam logic [1:0] IDX_FIRST = first_idx(MSB_FIRST);
    localparam logic [1:0] IDX_LAST  = last_idx(MSB_FIRST);
    localparam logic [1:0] IDX_STEP  = MSB_FIRST ? 2'd3 : 2'd1;

    logic [0:0] state_q, state_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] sel_q, sel_d;
    logic       mux_bit;
    logic       in_xfer;
    logic       out_beat;

    mux4to1_case u_mux (
        .d (hold_q),
        .s (sel_q),
        .y (mux_bit)
    );

    assign busy      = (state_q == ST_SEND);
    assign out_valid = busy;
    assign out_last  = busy && (sel_q == IDX_LAST);
    assign out_bit   = busy && mux_bit;
    assign sel       = sel_q;

    // Reload on the final beat is what allows gap-free back-to-back words.
    assign in_ready = rst_n && (!busy || (out_last && out_ready));
    assign in_xfer  = in_valid && in_ready;
    assign out_beat = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        sel_d   = sel_q;
        if (in_xfer) begin
            state_d = ST_SEND;
            hold_d  = in_data;
            sel_d   = IDX_FIRST;
        end else if (out_beat) begin
            if (out_last)
                state_d = ST_IDLE;
            else
                sel_d = sel_q + IDX_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            hold_q  <= 4'd0;
            sel_q   <= IDX_FIRST;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            sel_q   <= sel_d;
        end
    end

endmodule

// File: tb/tb_mux4_serializer.sv
// Runs both select orders side by side on shared stimulus, checked against a beat-queue model.
module tb_mux4_serializer;

    typedef struct packed {
        logic       b;
        logic [1:0] s;
        logic       l;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst_n, in_valid, out_ready;
    logic [3:0] in_data;
    logic [1:0] in_ready, out_valid, out_bit, out_last, busy;
    logic [1:0] sel0, sel1;

    int    total  = 0;
    int    passed = 0;
    beat_t q0[$], q1[$];
    bit    fresh;

    always #5 clk = ~clk;

    mux4_serializer #(.MSB_FIRST(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_data(in_data), .out_valid(out_valid[0]), .out_ready(out_ready),
        .out_bit(out_bit[0]), .out_last(out_last[0]), .sel(sel0), .busy(busy[0])
    );

    mux4_serializer #(.MSB_FIRST(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_data(in_data), .out_valid(out_valid[1]), .out_ready(out_ready),
        .out_bit(out_bit[1]), .out_last(out_last[1]), .sel(sel1), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    function automatic logic exp_in_ready();
        return rst_n && (q0.size() == 0 || (q0.size() == 1 && out_ready));
    endfunction

    task automatic check_dut(input int k, input beat_t q[$]);
        logic [1:0] s;
        string      p;
        s = (k == 0) ? sel0 : sel1;
        p = (k == 0) ? "lsb" : "msb";
        chk({p, "_in_ready"}, {3'b0, in_ready[k]}, {3'b0, exp_in_ready()});
        chk({p, "_out_valid"}, {3'b0, out_valid[k]}, {3'b0, q.size() != 0});
        chk({p, "_busy"}, {3'b0, busy[k]}, {3'b0, q.size() != 0});
        if (q.size() != 0) begin
            chk({p, "_out_bit"}, {3'b0, out_bit[k]}, {3'b0, q[0].b});
            chk({p, "_sel"}, {2'b0, s}, {2'b0, q[0].s});
            chk({p, "_out_last"}, {3'b0, out_last[k]}, {3'b0, q[0].l});
        end else begin
            chk({p, "_out_last_idle"}, {3'b0, out_last[k]}, 4'd0);
            if (fresh) begin
                chk({p, "_sel_reset"}, {2'b0, s}, (k == 0) ? 4'd0 : 4'd3);
                chk({p, "_out_bit_reset"}, {3'b0, out_bit[k]}, 4'd0);
            end
        end
    endtask

    // One clock: drive inputs, check outputs, then advance the model on the edge.
    task automatic cyc(input logic v, input logic [3:0] d, input logic ordy, input logic rn);
        logic rdy;
        beat_t e;
        in_valid  = v;
        in_data   = d;
        out_ready = ordy;
        rst_n     = rn;
        #1;
        check_dut(0, q0);
        check_dut(1, q1);
        rdy = exp_in_ready();
        @(posedge clk);
        if (!rn) begin
            q0 = {};
            q1 = {};
            fresh = 1'b1;
        end else begin
            if (q0.size() != 0 && ordy) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (v && rdy) begin
                fresh = 1'b0;
                for (int j = 0; j < 4; j++) begin
                    e.b = d[j];     e.s = 2'(j);     e.l = (j == 3); q0.push_back(e);
                    e.b = d[3 - j]; e.s = 2'(3 - j); e.l = (j == 3); q1.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 4'd0; out_ready = 1'b1;
        fresh = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 1, 1);

        // single word, then MSB-order pattern
        cyc(1, 4'b1011, 1, 1);
        repeat (5) cyc(0, 4'h0, 1, 1);
        cyc(1, 4'b0010, 1, 1);
        repeat (5) cyc(0, 4'h0, 1, 1);

        // stall during beat 2
        cyc(1, 4'b1100, 1, 1);
        cyc(0, 4'h0, 1, 1);
        repeat (3) cyc(0, 4'h0, 0, 1);
        repeat (4) cyc(0, 4'h0, 1, 1);

        // back-to-back with in_valid held high
        cyc(1, 4'hA, 1, 1);
        repeat (4) cyc(1, 4'h5, 1, 1);
        repeat (5) cyc(0, 4'h0, 1, 1);

        // reset mid-word
        cyc(1, 4'hF, 1, 1);
        cyc(0, 4'h0, 1, 1);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 1, 0);
        cyc(0, 4'h0, 1, 1);

        // input changes while not ready are ignored
        cyc(1, 4'h6, 1, 1);
        repeat (3) cyc(1, 4'($urandom), 1, 1);
        cyc(0, 4'h9, 1, 1);
        cyc(1, 4'h3, 0, 1);
        repeat (2) cyc(1, 4'($urandom), 0, 1);
        repeat (5) cyc(0, 4'($urandom), 1, 1);

        // randomized traffic with occasional reset
        for (int i = 0; i < 400; i++)
            cyc(1'($urandom), 4'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 60) != 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/mux4_serializer.md
# mux4_serializer

Parallel-to-serial front end for the team's 4:1 multiplexer stage. Accepts a 4-bit word over a valid/ready handshake and generates the 2-bit select sequence that steps a 4:1 mux across the latched word. It emits one bit per accepted output beat, with a last-beat flag. It sits directly upstream of the mux select input and downstream of any word producer.

## Interface
- `MSB_FIRST`, default 0: 0 = select order 0,1,2,3; 1 = select order 3,2,1,0.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset, sampled on the rising edge of `clk`.
- `in_valid` input 1: `in_data` is valid.
- `in_ready` output 1: block can accept a word this cycle.
- `in_data` input 4: word to serialize; bit i is mux input i.
- `out_valid` output 1: `out_bit` is valid.
- `out_ready` input 1: downstream consumes `out_bit` this cycle.
- `out_bit` output 1: currently selected bit of the latched word.
- `out_last` output 1: current beat is the 4th (final) bit of the word.
- `sel` output 2: select currently driven to the 4:1 mux.
- `busy` output 1: a word is held and not yet fully sent.

## Operation
- State machine has two states.
  - `IDLE`: no word held.
  - `SEND`: word held in the 4-bit `hold` register.
- Transfers:
  - Input transfer: `in_valid && in_ready` at a rising edge.
  - Output beat: `out_valid && out_ready` at a rising edge.
- `IDLE`:
  - `in_ready=1` and `out_valid=0`.
  - On an input transfer: `hold <= in_data`, `sel <=` first index (0, or 3 if `MSB_FIRST`), go to `SEND`.
- `SEND`:
  - `out_valid=1` and `out_bit = hold[sel]`.
  - `out_last=1` when `sel` is the final index (3, or 0 if `MSB_FIRST`).
  - On an output beat that is not last: `sel` steps by +1, or by −1 if `MSB_FIRST`.
  - On the last output beat with no simultaneous input transfer: go to `IDLE`.
- Back-to-back words:
  - In `SEND`, `in_ready = out_last && out_ready`. This is a combinational path from `out_ready` and is documented for integrators.
  - Last output beat and input transfer on the same edge: load the new word, reset `sel` to the first index, stay in `SEND`. No bubble.
- Stall: while `out_ready=0`, `sel`, `out_bit`, `out_last` and `hold` remain stable. `out_valid` is never withdrawn once raised until its beat completes.
- `in_data` is sampled only on an input transfer. Changes at any other time have no effect.
- `busy = (state == SEND)`.
- Reset:
  - While `rst_n=0`, `in_ready` is forced to 0.
  - On a reset edge: state goes to `IDLE`, `hold=0`, `sel` goes to the first index, `out_valid=0`, `out_last=0`, `out_bit=0`, `busy=0`.
  - Reset mid-word discards the remaining bits. No partial `out_last` is issued.
- Index arithmetic is 2-bit. Wrap-around never occurs, because the last beat either reloads `sel` or leaves `SEND`.

## Timing
- Latency: word accepted at edge k, so the first bit has `out_valid=1` in the cycle after edge k. There is no combinational path from input to output data.
- Throughput: with `out_ready` held high and a continuous input supply, one word per 4 cycles and one bit per cycle.
- Outputs `out_valid`, `out_bit`, `out_last`, `sel` and `busy` are functions of registers only.
- `in_ready` depends combinationally on `out_ready` in `SEND` only.
- First cycle after reset release: `in_ready=1`.

## Structure
- Shared defines header `mux4_serializer_defs.vh` holds:
  - state encodings `ST_IDLE=1'b0`, `ST_SEND=1'b1`;
  - index constants `IDX_FIRST_LSB=2'd0`, `IDX_FIRST_MSB=2'd3`.
- One sub-module is natural: instantiate the team's existing `mux4to1_case` to form `out_bit` from `hold` and `sel`. This keeps the select path identical to the downstream mux stage.
- Remaining logic is a single `always @(posedge clk)` block with reset handling, plus continuous assigns.

## Test plan
- Reset then single word, `MSB_FIRST=0`:
  - Stimulus: `in_data=4'b1011`, `out_ready=1`.
  - Required: `sel` = 0,1,2,3; `out_bit` = 1,1,0,1; `out_last` high on the 4th beat only; `in_ready` returns to 1 in the following cycle.
- `MSB_FIRST=1`:
  - Stimulus: `in_data=4'b0010`.
  - Required: `sel` = 3,2,1,0; `out_bit` = 0,0,1,0.
- Stall:
  - Stimulus: `out_ready=0` for 3 cycles during beat 2 of `4'b1100`.
  - Required: `sel=1`, `out_bit=0`, `out_valid=1` held stable; the sequence resumes unchanged.
- Back-to-back:
  - Stimulus: words `4'hA` and `4'h5` with `in_valid` continuously high.
  - Required: 8 consecutive valid beats with bits 0,1,0,1,1,0,1,0; `in_ready` pulses only on the last beat.
- Reset mid-word:
  - Stimulus: assert `rst_n=0` during beat 2 of `4'hF`.
  - Required: the next cycle shows `out_valid=0`, `busy=0`, `sel=0`, `in_ready=0`; the cycle after release shows `in_ready=1`; no `out_last` is seen.
- Input ignored when not ready:
  - Stimulus: toggle `in_data` and `in_valid` during `SEND`.
  - Required: the output sequence reflects only the originally accepted word.
